// File: rtl/mem_wb_pipe_pkg.sv
// Shared MIPS opcode/funct encodings and writeback-source selects for the MEM->WB path.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package mem_wb_pipe_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2a;
    localparam logic [5:0] FN_SLTU  = 6'h2b;

    localparam logic [4:0] REG_RA   = 5'd31;

    // Source of register-file write data
    typedef enum logic [1:0] {
        WB_SEL_ALU = 2'd0,
        WB_SEL_MEM = 2'd1,
        WB_SEL_PC  = 2'd2
    } wb_sel_e;

    function automatic logic [5:0] instr_op(input logic [31:0] instr);
        return instr[31:26];
    endfunction

    function automatic logic [5:0] instr_fn(input logic [31:0] instr);
        return instr[5:0];
    endfunction

endpackage

// File: rtl/mem_wb_pipe_wb_decode.sv
// Writeback decode: instruction + overflow flag -> register write enable, destination, data source.
// Latency: purely combinational.
// Backpressure: none; evaluated on whatever the stage register holds.
module wb_decode
    import mem_wb_pipe_pkg::*;
(
    input  logic [31:0] i_instr,
    input  logic        i_ovf,
    output logic        o_regwrite,
    output logic [4:0]  o_dest,
    output wb_sel_e     o_wb_sel
);

    logic [5:0] w_op;
    logic [5:0] w_fn;
    logic [4:0] w_rt;
    logic [4:0] w_rd;
    logic       w_unused_bits;

    assign w_op = instr_op(i_instr);
    assign w_fn = instr_fn(i_instr);
    assign w_rt = i_instr[20:16];
    assign w_rd = i_instr[15:11];
    // rs and shamt never affect writeback
    assign w_unused_bits = ^{i_instr[25:21], i_instr[10:6]};

    // Classify the instruction; overflowed add/sub/addi are suppressed here
    always_comb begin
        o_regwrite = 1'b0;
        o_wb_sel   = WB_SEL_ALU;
        o_dest     = w_rt;
        if (w_op == OP_RTYPE) begin
            o_dest = w_rd;
            case (w_fn)
                FN_ADD, FN_SUB:                      o_regwrite = ~i_ovf;
                FN_ADDU, FN_SUBU, FN_AND, FN_OR,
                FN_XOR, FN_NOR, FN_SLLV, FN_SRLV,
                FN_SRAV, FN_SLL, FN_SRL, FN_SRA,
                FN_SLT, FN_SLTU, FN_MFHI, FN_MFLO:   o_regwrite = 1'b1;
                FN_JALR: begin
                    o_regwrite = 1'b1;
                    o_wb_sel   = WB_SEL_PC;
                end
                default:                             o_regwrite = 1'b0;
            endcase
        end else begin
            case (w_op)
                OP_ADDI:                             o_regwrite = ~i_ovf;
                OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI,
                OP_ORI, OP_XORI, OP_LUI:             o_regwrite = 1'b1;
                OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                    o_regwrite = 1'b1;
                    o_wb_sel   = WB_SEL_MEM;
                end
                OP_JAL: begin
                    o_regwrite = 1'b1;
                    o_dest     = REG_RA;
                    o_wb_sel   = WB_SEL_PC;
                end
                default:                             o_regwrite = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline register chain (DEPTH stages) with register-file writeback decode and hazard info.
// Latency: input sampled at edge n is on o_wb_* after edge n+DEPTH-1; outputs come only from stage regs.
// Backpressure: i_stall holds every stage; i_flush bubbles stage 0 only (reset > flush > stall).
module mem_wb_pipe
    import mem_wb_pipe_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 1,
    parameter int PC_OFFSET = 8
)(
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_stall,
    input  logic                 i_flush,
    input  logic [31:0]          i_mem_instr,
    input  logic [DATA_W-1:0]    i_mem_pc,
    input  logic [DATA_W-1:0]    i_mem_alu,
    input  logic [DATA_W-1:0]    i_mem_rdata,
    input  logic                 i_mem_overflow,
    output logic                 o_wb_we,
    output logic [4:0]           o_wb_addr,
    output logic [DATA_W-1:0]    o_wb_data,
    output logic [31:0]          o_wb_instr,
    output logic [DATA_W-1:0]    o_wb_pc,
    output logic [DEPTH-1:0]     o_pend_we,
    output logic [5*DEPTH-1:0]   o_pend_addr,
    output logic [3:0]           o_tnew
);

    localparam int                LAST      = DEPTH - 1;
    localparam logic [DATA_W-1:0] L_PC_OFF  = DATA_W'(PC_OFFSET);
    localparam logic [3:0]        L_TNEW    = 4'(DEPTH - 1);

    logic [DEPTH-1:0] w_pend_we;

    genvar k;
    generate
        for (k = 0; k < DEPTH; k++) begin : g_stg
            logic              r_valid;
            logic [31:0]       r_instr;
            logic [DATA_W-1:0] r_pc;
            logic [DATA_W-1:0] r_alu;
            logic [DATA_W-1:0] r_rdata;
            logic              r_ovf;

            logic              w_regwrite;
            logic [4:0]        w_dest;
            wb_sel_e           w_wb_sel;

            if (k == 0) begin : g_head
                // Stage 0: capture MEM bundle, or a zeroed bubble on flush
                always_ff @(posedge i_clk) begin
                    if (i_reset || i_flush) begin
                        r_valid <= 1'b0;
                        r_instr <= '0;
                        r_pc    <= '0;
                        r_alu   <= '0;
                        r_rdata <= '0;
                        r_ovf   <= 1'b0;
                    end else if (!i_stall) begin
                        r_valid <= 1'b1;
                        r_instr <= i_mem_instr;
                        r_pc    <= i_mem_pc;
                        r_alu   <= i_mem_alu;
                        r_rdata <= i_mem_rdata;
                        r_ovf   <= i_mem_overflow;
                    end
                end
            end else begin : g_body
                // Later stages: shift from the previous stage unless stalled
                always_ff @(posedge i_clk) begin
                    if (i_reset) begin
                        r_valid <= 1'b0;
                        r_instr <= '0;
                        r_pc    <= '0;
                        r_alu   <= '0;
                        r_rdata <= '0;
                        r_ovf   <= 1'b0;
                    end else if (!i_stall) begin
                        r_valid <= g_stg[k-1].r_valid;
                        r_instr <= g_stg[k-1].r_instr;
                        r_pc    <= g_stg[k-1].r_pc;
                        r_alu   <= g_stg[k-1].r_alu;
                        r_rdata <= g_stg[k-1].r_rdata;
                        r_ovf   <= g_stg[k-1].r_ovf;
                    end
                end
            end

            wb_decode u_dec (
                .i_instr    (r_instr),
                .i_ovf      (r_ovf),
                .o_regwrite (w_regwrite),
                .o_dest     (w_dest),
                .o_wb_sel   (w_wb_sel)
            );

            // $0 is hardwired, so a write to it is never pending
            assign w_pend_we[k]          = r_valid & w_regwrite & (w_dest != 5'd0);
            assign o_pend_addr[5*k +: 5] = w_dest;
        end
    endgenerate

    assign o_pend_we  = w_pend_we;
    assign o_wb_we    = w_pend_we[LAST];
    assign o_wb_addr  = g_stg[LAST].w_dest;
    assign o_wb_instr = g_stg[LAST].r_instr;
    assign o_wb_pc    = g_stg[LAST].r_pc;
    assign o_tnew     = w_pend_we[0] ? L_TNEW : 4'd0;

    // Write-data source select for the last stage; link address wraps modulo 2^DATA_W
    always_comb begin
        o_wb_data = g_stg[LAST].r_alu;
        case (g_stg[LAST].w_wb_sel)
            WB_SEL_MEM: o_wb_data = g_stg[LAST].r_rdata;
            WB_SEL_PC:  o_wb_data = g_stg[LAST].r_pc + L_PC_OFF;
            default:    o_wb_data = g_stg[LAST].r_alu;
        endcase
    end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Scoreboard bench for mem_wb_pipe at DEPTH=1 and DEPTH=3 with hand-computed expectations.
// Latency: stimulus pushes the expected post-edge output tuple tagged with its edge number.
// Backpressure: monitors pop and compare per edge, decoupled from the stimulus process.
module tb_mem_wb_pipe;

    typedef struct {
        int          cyc;
        string       name;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [3:0]  tnew;
        logic [2:0]  pw;
        logic [14:0] pa;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    exp_t q1[$];
    exp_t q3[$];

    // DEPTH=1 instance
    logic        d1_reset = 1'b1, d1_stall = 1'b0, d1_flush = 1'b0, d1_ovf = 1'b0;
    logic [31:0] d1_instr = '0, d1_pc = '0, d1_alu = '0, d1_rdata = '0;
    logic        d1_we;
    logic [4:0]  d1_addr;
    logic [31:0] d1_data, d1_winstr, d1_wpc;
    logic [0:0]  d1_pw;
    logic [4:0]  d1_pa;
    logic [3:0]  d1_tnew;

    mem_wb_pipe #(.DATA_W(32), .DEPTH(1), .PC_OFFSET(8)) u_d1 (
        .i_clk(clk), .i_reset(d1_reset), .i_stall(d1_stall), .i_flush(d1_flush),
        .i_mem_instr(d1_instr), .i_mem_pc(d1_pc), .i_mem_alu(d1_alu),
        .i_mem_rdata(d1_rdata), .i_mem_overflow(d1_ovf),
        .o_wb_we(d1_we), .o_wb_addr(d1_addr), .o_wb_data(d1_data),
        .o_wb_instr(d1_winstr), .o_wb_pc(d1_wpc),
        .o_pend_we(d1_pw), .o_pend_addr(d1_pa), .o_tnew(d1_tnew)
    );

    // DEPTH=3 instance
    logic        d3_reset = 1'b1, d3_stall = 1'b0, d3_flush = 1'b0, d3_ovf = 1'b0;
    logic [31:0] d3_instr = '0, d3_pc = '0, d3_alu = '0, d3_rdata = '0;
    logic        d3_we;
    logic [4:0]  d3_addr;
    logic [31:0] d3_data, d3_winstr, d3_wpc;
    logic [2:0]  d3_pw;
    logic [14:0] d3_pa;
    logic [3:0]  d3_tnew;

    mem_wb_pipe #(.DATA_W(32), .DEPTH(3), .PC_OFFSET(8)) u_d3 (
        .i_clk(clk), .i_reset(d3_reset), .i_stall(d3_stall), .i_flush(d3_flush),
        .i_mem_instr(d3_instr), .i_mem_pc(d3_pc), .i_mem_alu(d3_alu),
        .i_mem_rdata(d3_rdata), .i_mem_overflow(d3_ovf),
        .o_wb_we(d3_we), .o_wb_addr(d3_addr), .o_wb_data(d3_data),
        .o_wb_instr(d3_winstr), .o_wb_pc(d3_wpc),
        .o_pend_we(d3_pw), .o_pend_addr(d3_pa), .o_tnew(d3_tnew)
    );

    task automatic set1(input logic rst, input logic stl, input logic fl,
                        input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] alu, input logic [31:0] rd, input logic ov);
        d1_reset = rst; d1_stall = stl; d1_flush = fl;
        d1_instr = ins; d1_pc = pc; d1_alu = alu; d1_rdata = rd; d1_ovf = ov;
    endtask

    task automatic set3(input logic rst, input logic stl, input logic fl,
                        input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] alu, input logic [31:0] rd, input logic ov);
        d3_reset = rst; d3_stall = stl; d3_flush = fl;
        d3_instr = ins; d3_pc = pc; d3_alu = alu; d3_rdata = rd; d3_ovf = ov;
    endtask

    // Expected tuple after the coming edge
    task automatic push(input int which, input string nm, input logic we,
                        input logic [4:0] a, input logic [31:0] d,
                        input logic [31:0] ins, input logic [31:0] pc,
                        input logic [3:0] tn, input logic [2:0] pw, input logic [14:0] pa);
        exp_t e;
        e.cyc = cyc + 1; e.name = nm; e.we = we; e.addr = a; e.data = d;
        e.instr = ins; e.pc = pc; e.tnew = tn; e.pw = pw; e.pa = pa;
        if (which == 1) q1.push_back(e);
        else            q3.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string dut, input exp_t e,
                         input logic we, input logic [4:0] a, input logic [31:0] d,
                         input logic [31:0] ins, input logic [31:0] pc,
                         input logic [3:0] tn, input logic [2:0] pw, input logic [14:0] pa);
        n_cmp++;
        if ({we, a, d, ins, pc, tn, pw, pa} !==
            {e.we, e.addr, e.data, e.instr, e.pc, e.tnew, e.pw, e.pa}) begin
            n_fail++;
            $display("FAIL %s/%s: got we=%b addr=%0d data=%h instr=%h pc=%h tnew=%0d pend_we=%b pend_addr=%h ; want we=%b addr=%0d data=%h instr=%h pc=%h tnew=%0d pend_we=%b pend_addr=%h",
                     dut, e.name, we, a, d, ins, pc, tn, pw, pa,
                     e.we, e.addr, e.data, e.instr, e.pc, e.tnew, e.pw, e.pa);
        end
    endtask

    // Monitor for the DEPTH=1 instance
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            while (q1.size() > 0 && q1[0].cyc == cyc) begin
                e = q1.pop_front();
                check("d1", e, d1_we, d1_addr, d1_data, d1_winstr, d1_wpc, d1_tnew,
                      {2'b00, d1_pw}, {10'd0, d1_pa});
            end
            while (q1.size() > 0 && q1[0].cyc < cyc) begin
                e = q1.pop_front();
                n_cmp++; n_fail++;
                $display("FAIL d1/%s: expectation missed at cycle %0d", e.name, cyc);
            end
        end
    end

    // Monitor for the DEPTH=3 instance
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            while (q3.size() > 0 && q3[0].cyc == cyc) begin
                e = q3.pop_front();
                check("d3", e, d3_we, d3_addr, d3_data, d3_winstr, d3_wpc, d3_tnew,
                      d3_pw, d3_pa);
            end
            while (q3.size() > 0 && q3[0].cyc < cyc) begin
                e = q3.pop_front();
                n_cmp++; n_fail++;
                $display("FAIL d3/%s: expectation missed at cycle %0d", e.name, cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

    localparam logic [31:0] ADDU  = 32'h00221821;
    localparam logic [31:0] JAL   = 32'h0C000010;
    localparam logic [31:0] LW    = 32'h8C050004;
    localparam logic [31:0] ADD   = 32'h00222020;
    localparam logic [31:0] ADDIU = 32'h24000005;
    localparam logic [31:0] JALR  = 32'h0060F809;

    initial begin
        // ---------------- DEPTH = 1 ----------------
        set1(1, 0, 0, 0, 0, 0, 0, 0);
        push(1, "reset", 0, 0, 0, 0, 0, 0, 0, 0);                          tick();
        set1(0, 0, 0, ADDU, 32'h1000, 32'h15, 32'h99, 0);
        push(1, "addu", 1, 3, 32'h15, ADDU, 32'h1000, 0, 1, 3);             tick();
        set1(0, 0, 0, JAL, 32'h3000, 32'h1234, 0, 0);
        push(1, "jal", 1, 31, 32'h3008, JAL, 32'h3000, 0, 1, 31);           tick();
        set1(0, 0, 0, LW, 32'h3004, 32'h4, 32'hDEADBEEF, 0);
        push(1, "lw", 1, 5, 32'hDEADBEEF, LW, 32'h3004, 0, 1, 5);           tick();
        set1(0, 0, 0, ADD, 32'h3008, 32'h7FFFFFFF, 0, 1);
        push(1, "add_ovf", 0, 4, 32'h7FFFFFFF, ADD, 32'h3008, 0, 0, 4);     tick();
        set1(0, 0, 0, ADD, 32'h300C, 32'h30, 0, 0);
        push(1, "add", 1, 4, 32'h30, ADD, 32'h300C, 0, 1, 4);               tick();
        set1(0, 0, 0, ADDIU, 32'h3010, 32'h5, 0, 0);
        push(1, "addiu_r0", 0, 0, 32'h5, ADDIU, 32'h3010, 0, 0, 0);         tick();
        set1(0, 0, 0, ADDU, 32'h1010, 32'h21, 0, 0);
        push(1, "addu2", 1, 3, 32'h21, ADDU, 32'h1010, 0, 1, 3);            tick();
        for (int i = 0; i < 3; i++) begin
            set1(0, 1, 0, LW, 32'h4000, 32'h2, 32'h1, 0);
            push(1, "stall", 1, 3, 32'h21, ADDU, 32'h1010, 0, 1, 3);        tick();
        end
        set1(0, 0, 0, JALR, 32'hFFFFFFFC, 32'hABCD, 0, 0);
        push(1, "jalr_wrap", 1, 31, 32'h4, JALR, 32'hFFFFFFFC, 0, 1, 31);   tick();
        set1(0, 0, 1, LW, 32'h5000, 32'h2, 32'h3, 0);
        push(1, "flush", 0, 0, 0, 0, 0, 0, 0, 0);                           tick();

        // ---------------- DEPTH = 3 ----------------
        set3(1, 0, 0, 0, 0, 0, 0, 0);
        push(3, "reset", 0, 0, 0, 0, 0, 0, 3'b000, 15'h0000);               tick();
        set3(0, 0, 0, LW, 32'h100, 32'h4, 32'hCAFEF00D, 0);
        push(3, "lw_enter", 0, 0, 0, 0, 0, 2, 3'b001, 15'h0005);            tick();
        set3(0, 0, 0, ADDU, 32'h104, 32'h15, 0, 0);
        push(3, "addu_enter", 0, 0, 0, 0, 0, 2, 3'b011, 15'h00A3);          tick();
        set3(0, 0, 0, ADD, 32'h108, 32'h77, 0, 1);
        push(3, "lw_out", 1, 5, 32'hCAFEF00D, LW, 32'h100, 0, 3'b110, 15'h1464); tick();
        set3(0, 1, 1, JAL, 32'h300, 0, 0, 0);
        push(3, "flush_stall", 1, 5, 32'hCAFEF00D, LW, 32'h100, 0, 3'b110, 15'h1460); tick();
        set3(0, 1, 0, LW, 32'h400, 0, 32'h9, 0);
        push(3, "stall_hold", 1, 5, 32'hCAFEF00D, LW, 32'h100, 0, 3'b110, 15'h1460); tick();
        set3(0, 0, 0, JAL, 32'h200, 0, 0, 0);
        push(3, "addu_out", 1, 3, 32'h15, ADDU, 32'h104, 2, 3'b101, 15'h0C1F); tick();
        set3(0, 0, 0, ADDU, 32'h204, 32'h55, 0, 0);
        push(3, "bubble_out", 0, 0, 0, 0, 0, 2, 3'b011, 15'h03E3);          tick();
        set3(0, 0, 0, LW, 32'h208, 32'h8, 32'h11, 0);
        push(3, "jal_out", 1, 31, 32'h208, JAL, 32'h200, 2, 3'b111, 15'h7C65); tick();
        set3(1, 0, 0, LW, 32'h20C, 32'h8, 32'h22, 0);
        push(3, "reset_mid", 0, 0, 0, 0, 0, 0, 3'b000, 15'h0000);           tick();
        for (int i = 0; i < 3; i++) begin
            set3(0, 0, 1, LW, 32'h210, 32'h8, 32'h33, 0);
            push(3, "post_reset", 0, 0, 0, 0, 0, 0, 3'b000, 15'h0000);      tick();
        end

        repeat (3) @(posedge clk);
        #5;
        if (q1.size() != 0 || q3.size() != 0) begin
            n_cmp++; n_fail++;
            $display("FAIL drain: %0d/%0d expectations left unchecked, want 0/0", q1.size(), q3.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_wb_pipe.md
# mem_wb_pipe

Parametrised MEM→WB pipeline register and writeback controller for the five-stage MIPS core. It latches the MEM-stage bundle (instruction, PC, ALU result, load data, overflow flag) through `DEPTH` register stages. It decodes register-file write enable, destination and write data at the last stage, and publishes pending-write and Tnew information for the hazard unit. `DEPTH` > 1 supports later cores with extra writeback stages, such as load-align or MDU result.

## Interface
- `DATA_W`, 32, datapath width of PC/ALU/memory words
- `DEPTH`, 1, number of register stages between MEM and register-file write (1..8)
- `PC_OFFSET`, 8, value added to PC for link writes (jal/jalr)
- Reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high; clears all stages
- `stall`  in  1  hold every stage
- `flush`  in  1  load a bubble into stage 0
- `mem_instr`  in  32  instruction leaving MEM
- `mem_pc`  in  DATA_W  its PC
- `mem_alu`  in  DATA_W  ALU/MDU result
- `mem_rdata`  in  DATA_W  load data (already extended)
- `mem_overflow`  in  1  arithmetic overflow for add/sub/addi
- `wb_we`  out  1  register-file write enable
- `wb_addr`  out  5  destination register
- `wb_data`  out  DATA_W  write data
- `wb_instr`  out  32  instruction in last stage (debug/trace)
- `wb_pc`  out  DATA_W  PC in last stage
- `pend_we`  out  DEPTH  per-stage "will write a nonzero register"
- `pend_addr`  out  5*DEPTH  per-stage destination, stage k at bits [5k+4:5k]
- `tnew`  out  4  cycles until stage-0 instruction's result reaches `wb_data`

## Operation
- Each stage holds {valid, instr, pc, alu, rdata, ovf}. Stage 0 loads from `mem_*` with valid=1; stage k loads from stage k-1.
- Priority per edge: `reset` > `flush` > `stall`.
  - `flush`: stage 0 gets the bubble (valid=0, all fields 0). Stages 1..DEPTH-1 hold if `stall`, else shift.
  - `stall` alone: all stages hold.
- Decode is combinational, per stage:
  - RegWrite = add/sub/addi with ovf=0, OR addu, subu, and, or, xor, nor, sllv, srlv, srav, sll, srl, sra, slt, sltu, jalr, mfhi, mflo, ori, lui, addiu, andi, xori, slti, sltiu, lb, lbu, lh, lhu, lw, jal.
  - Destination: jal → 31; R-type (op 0) → rd; otherwise → rt.
  - `pend_we`[k] = valid & RegWrite & dest≠0.
- Last stage drives the outputs:
  - `wb_we` = `pend_we`[DEPTH-1]; `wb_addr` = its destination.
  - `wb_data` = pc+PC_OFFSET (modulo 2^DATA_W) for jal/jalr; rdata for loads; alu otherwise.
- `tnew` = DEPTH-1 if `pend_we`[0], else 0.

## Timing
- Latency: an input sampled at edge n appears on `wb_*` after edge n+DEPTH-1. All outputs are combinational from stage registers, so there is no same-cycle input→output path.
- After reset all stages are bubbles, so `wb_we`=0, `wb_addr`=0, `wb_data`=0, `wb_instr`=0, `wb_pc`=0, `pend_we`=0, `pend_addr`=0, `tnew`=0.
- Reset mid-stream discards all in-flight instructions; nothing is written afterward.
- During `stall`, `wb_we` stays asserted and repeats the same write; writes are idempotent.
- Overflowed add/sub/addi pass through as valid with `wb_we`=0; exception handling is upstream.
- Destination $0 never produces `wb_we`=1 or `pend_we`=1.

## Structure
- Opcode/funct macros (`OP`, `FUNC`, `ADD_FUNC`, …, `JAL`) come from the shared `defines.v`.
- Add `WB_SEL_ALU`/`WB_SEL_MEM`/`WB_SEL_PC` (2-bit) encodings to `defines.v`.
- Sub-module `wb_decode`: combinational, instr+ovf → {regwrite, dest, wb_sel}. Instantiated DEPTH times via generate.
- Stage array is a generate loop in `mem_wb_pipe`.

## Test plan
- DEPTH=1: `mem_instr`=0x00221821 (addu $3,$1,$2), alu=0x15 → next cycle `wb_we`=1, `wb_addr`=3, `wb_data`=0x15, `tnew`=0.
- jal 0x0C000010 at pc=0x00003000 → `wb_addr`=31, `wb_data`=0x00003008. lw 0x8C050004 with rdata=0xDEADBEEF → `wb_addr`=5, data 0xDEADBEEF.
- add 0x00222020 with `mem_overflow`=1 → `wb_we`=0. Same instruction with overflow=0 → `wb_we`=1, addr 4. addiu 0x24000005 (dest $0) → `wb_we`=0, `pend_we`=0.
- DEPTH=3: lw to $5 → `tnew`=2 the cycle after entry and `pend_addr`[4:0]=5. Write emerges on `wb_*` two edges later.
- Stall held 3 cycles with addu in flight → outputs frozen. Flush+stall at DEPTH=3 → stage 0 bubble, stages 1–2 unchanged.
- Reset asserted while three valid writes are in flight → all outputs 0 next cycle; no `wb_we` pulses afterward.
